// File: rtl/sw_cmd_scheduler.sv
// rtl/sw_cmd_scheduler.sv - command front-end merging buttons and UART commands for the stopwatch
//
// Purpose:
//   Turns debounced button pulses and ASCII UART commands into single-cycle
//   run/stop and clear pulses for the stopwatch control unit, owns the
//   watch/stopwatch mode bit, and optionally acknowledges each UART command
//   with one byte pushed into the TX FIFO.
//
// Parameters:
//   ACK_EN    1: push one ack byte per UART command, 0: no TX traffic
//   BTN_PRIO  1: a pending button beats a waiting RX byte in IDLE, 0: RX first
//
// Ports:
//   clk            in   1  system clock
//   rst            in   1  synchronous active-high reset
//   i_btn_runstop  in   1  debounced run/stop button pulse
//   i_btn_clear    in   1  debounced clear button pulse
//   i_btn_mode     in   1  debounced mode button pulse (toggles o_mode)
//   i_rx_empty     in   1  RX FIFO empty; i_rx_data valid while low
//   i_rx_data      in   8  RX FIFO head byte (first-word-fall-through)
//   o_rx_pop       out  1  RX FIFO pop, one cycle per command
//   i_tx_full      in   1  TX FIFO full
//   o_tx_push      out  1  TX FIFO push
//   o_tx_data      out  8  ack byte
//   o_runstop      out  1  run/stop pulse to stopwatch control unit
//   o_clear        out  1  clear pulse to stopwatch control unit
//   o_mode         out  1  0 = watch, 1 = stopwatch
//   o_cmd_err      out  1  pulse on a rejected UART command

module sw_cmd_scheduler #(
   parameter bit ACK_EN   = 1'b1,
   parameter bit BTN_PRIO = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_btn_runstop,
   input  logic       i_btn_clear,
   input  logic       i_btn_mode,
   input  logic       i_rx_empty,
   input  logic [7:0] i_rx_data,
   output logic       o_rx_pop,
   input  logic       i_tx_full,
   output logic       o_tx_push,
   output logic [7:0] o_tx_data,
   output logic       o_runstop,
   output logic       o_clear,
   output logic       o_mode,
   output logic       o_cmd_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_ACK   = 2'd3
   } state_t;

   localparam logic [7:0] ACK_ERR = 8'h3F;   // '?'
   localparam logic [7:0] ACK_RUN = 8'h52;   // 'R'
   localparam logic [7:0] ACK_CLR = 8'h43;   // 'C'
   localparam logic [7:0] ACK_MOD = 8'h4D;   // 'M'

   state_t     r_state;
   state_t     w_state_nxt;

   logic       r_pend_run;
   logic       r_pend_clr;
   logic       r_pend_mode;
   logic [7:0] r_cmd;
   logic       r_runstop;
   logic       r_clear;
   logic       r_cmd_err;
   logic       r_mode;
   logic [7:0] r_tx_data;

   logic       w_btn_any;
   logic       w_issue_btn;
   logic       w_go_fetch;
   logic       w_iss_clr;
   logic       w_iss_run;
   logic       w_iss_mode;
   logic       w_cmd_r;
   logic       w_cmd_c;
   logic       w_cmd_m;

   // Case-insensitive command decode of the latched byte
   assign w_cmd_r = (r_cmd == 8'h52) || (r_cmd == 8'h72);
   assign w_cmd_c = (r_cmd == 8'h43) || (r_cmd == 8'h63);
   assign w_cmd_m = (r_cmd == 8'h4D) || (r_cmd == 8'h6D);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_go_fetch) w_state_nxt = S_FETCH;
         S_FETCH: w_state_nxt = S_EXEC;
         S_EXEC:  w_state_nxt = ACK_EN ? S_ACK : S_IDLE;
         S_ACK:   if (!i_tx_full) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output / arbitration logic
   always_comb begin
      w_btn_any   = r_pend_clr | r_pend_run | r_pend_mode;
      // In IDLE a button wins unless RX has priority and a byte is waiting
      w_issue_btn = (r_state == S_IDLE) && w_btn_any && (BTN_PRIO || i_rx_empty);
      w_go_fetch  = (r_state == S_IDLE) && !i_rx_empty && (!BTN_PRIO || !w_btn_any);
      // One button per cycle: clear > runstop > mode
      w_iss_clr   = w_issue_btn && r_pend_clr;
      w_iss_run   = w_issue_btn && !r_pend_clr && r_pend_run;
      w_iss_mode  = w_issue_btn && !r_pend_clr && !r_pend_run && r_pend_mode;
      o_rx_pop    = (r_state == S_FETCH);
      o_tx_push   = (r_state == S_ACK) && !i_tx_full;
   end

   // Pending flags, command latch and registered output pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_run  <= 1'b0;
         r_pend_clr  <= 1'b0;
         r_pend_mode <= 1'b0;
         r_cmd       <= 8'h00;
         r_runstop   <= 1'b0;
         r_clear     <= 1'b0;
         r_cmd_err   <= 1'b0;
         r_mode      <= 1'b0;
         r_tx_data   <= 8'h00;
      end else begin
         r_runstop <= 1'b0;
         r_clear   <= 1'b0;
         r_cmd_err <= 1'b0;

         // A new press on the issuing edge re-arms the flag so it is not lost
         r_pend_clr  <= i_btn_clear   | (r_pend_clr  & ~w_iss_clr);
         r_pend_run  <= i_btn_runstop | (r_pend_run  & ~w_iss_run);
         r_pend_mode <= i_btn_mode    | (r_pend_mode & ~w_iss_mode);

         if (r_state == S_FETCH) begin
            r_cmd <= i_rx_data;
         end

         if (w_iss_clr) begin
            // Dropped silently in watch mode
            r_clear <= r_mode;
         end else if (w_iss_run) begin
            r_runstop <= r_mode;
         end else if (w_iss_mode) begin
            r_mode <= ~r_mode;
         end else if (r_state == S_EXEC) begin
            if (w_cmd_m) begin
               r_mode    <= ~r_mode;
               r_tx_data <= ACK_MOD;
            end else if (w_cmd_r && r_mode) begin
               r_runstop <= 1'b1;
               r_tx_data <= ACK_RUN;
            end else if (w_cmd_c && r_mode) begin
               r_clear   <= 1'b1;
               r_tx_data <= ACK_CLR;
            end else begin
               r_cmd_err <= 1'b1;
               r_tx_data <= ACK_ERR;
            end
         end
      end
   end

   assign o_runstop = r_runstop;
   assign o_clear   = r_clear;
   assign o_cmd_err = r_cmd_err;
   assign o_mode    = r_mode;
   assign o_tx_data = r_tx_data;

endmodule
